// File: rtl/fir_pkg.sv
// Shared widths, tap count and the default linear-phase coefficient set
// for the 8-tap low-pass FIR.
package fir_pkg;

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int OUT_W  = 32;
  localparam int TAPS   = 8;
  localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef coef_t coef_arr_t [TAPS];

  // Symmetric set; DC gain 44, so 16-bit inputs stay well inside 32 bits.
  localparam coef_arr_t FIR_COEFS = '{16'sd1, 16'sd3, 16'sd7, 16'sd11,
                                      16'sd11, 16'sd7, 16'sd3, 16'sd1};

endpackage

// File: rtl/fir_tap_mac.sv
// One combinational multiply-accumulate stage of the tap chain:
// acc_out = acc_in + coef * sample, all signed.
module fir_tap_mac #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 35
) (
  input  logic [DATA_W-1:0] sample,
  input  logic [COEF_W-1:0] coef,
  input  logic [ACC_W-1:0]  acc_in,
  output logic [ACC_W-1:0]  acc_out
);

  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;

  assign prod     = $signed(sample) * $signed(coef);
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign acc_out  = acc_in + prod_ext;

endmodule

// File: rtl/fir_filter.sv
// Direct-form FIR: one sample in and one registered result out per clock.
// The current sample feeds tap 0 directly, so the result lags the input by one cycle.
module fir_filter
  import fir_pkg::*;
#(
  parameter int DATA_W = fir_pkg::DATA_W,
  parameter int COEF_W = fir_pkg::COEF_W,
  parameter int OUT_W  = fir_pkg::OUT_W,
  parameter int TAPS   = fir_pkg::TAPS,
  parameter logic signed [COEF_W-1:0] COEFS [TAPS] = FIR_COEFS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample_in,
  output logic [OUT_W-1:0]  filter_out
);

  localparam int SUM_W = DATA_W + COEF_W + $clog2(TAPS);

  logic [TAPS-2:0][DATA_W-1:0] x_q;
  logic [TAPS-1:0][DATA_W-1:0] taps;
  logic [TAPS:0][SUM_W-1:0]    acc;

  assign taps[0] = sample_in;
  assign acc[0]  = '0;

  genvar k;
  generate
    for (k = 1; k < TAPS; k++) begin : g_tap
      assign taps[k] = x_q[k-1];
    end
    for (k = 0; k < TAPS; k++) begin : g_mac
      fir_tap_mac #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (SUM_W)
      ) u_mac (
        .sample  (taps[k]),
        .coef    (COEFS[k]),
        .acc_in  (acc[k]),
        .acc_out (acc[k+1])
      );
    end
  endgenerate

  // Bits above OUT_W are dropped on purpose: out-of-range sums wrap.
  logic unused_acc_hi;
  assign unused_acc_hi = ^acc[TAPS][SUM_W-1:OUT_W] ^ ^acc[TAPS-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q        <= '0;
      filter_out <= '0;
    end else begin
      x_q[0] <= sample_in;
      for (int i = 1; i < TAPS-1; i++) x_q[i] <= x_q[i-1];
      filter_out <= acc[TAPS][OUT_W-1:0];
    end
  end

endmodule

// File: tb/tb_fir_filter.sv
// Self-checking bench for fir_filter: hand-computed vector table, a
// convolution scoreboard for the sine run, and reset corner cases.
module tb_fir_filter;

  localparam int TAPS = 8;
  localparam int C [TAPS] = '{1, 3, 7, 11, 11, 7, 3, 1};

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sample_in;
  logic [31:0] filter_out;

  always #5 clk = ~clk;

  fir_filter dut (
    .clk        (clk),
    .reset      (reset),
    .sample_in  (sample_in),
    .filter_out (filter_out)
  );

  int checks   = 0;
  int failures = 0;
  logic signed [31:0] exp_q [$];
  longint hist [TAPS-1];

  typedef struct {
    logic signed [15:0] s;
    logic               use_exp;
    logic signed [31:0] e;
  } vec_t;
  vec_t vecs [$];

  int sine [20] = '{0, 40, 75, 104, 122, 128, 122, 104, 75, 40,
                    0, -40, -75, -104, -122, -128, -122, -104, -75, -40};

  function automatic void clear_hist();
    for (int i = 0; i < TAPS-1; i++) hist[i] = 0;
  endfunction

  // Reference convolution: y = c0*s + sum c[k]*s(n-k).
  function automatic logic signed [31:0] model_step(input logic signed [15:0] s);
    longint acc;
    acc = C[0] * longint'(s);
    for (int i = 1; i < TAPS; i++) acc += C[i] * hist[i-1];
    for (int i = TAPS-2; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = longint'(s);
    return 32'(acc);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  task automatic drive(input logic signed [15:0] s, input logic use_exp,
                       input logic signed [31:0] e, input string name);
    logic signed [31:0] m;
    m = model_step(s);
    sample_in = s;
    exp_q.push_back(use_exp ? e : m);
    @(posedge clk);
    #1;
    check(name, filter_out, exp_q.pop_front());
  endtask

  task automatic add(input int s, input logic use_exp, input int e);
    vec_t v;
    v.s = 16'(s);
    v.use_exp = use_exp;
    v.e = 32'(e);
    vecs.push_back(v);
  endtask

  initial begin
    int imp [10] = '{256, 768, 1792, 2816, 2816, 1792, 768, 256, 0, 0};
    int stp [9]  = '{100, 400, 1100, 2200, 3300, 4000, 4300, 4400, 4400};

    // Table: impulses, step, then full-scale extremes (settled value on 8th row).
    for (int i = 0; i < 10; i++) add(i == 0 ? 256 : 0, 1'b1, imp[i]);
    for (int i = 0; i < 10; i++) add(i == 0 ? -256 : 0, 1'b1, -imp[i]);
    for (int i = 0; i < 9; i++)  add(100, 1'b1, stp[i]);
    for (int i = 0; i < 8; i++)  add(32767, i == 7, 1441748);
    for (int i = 0; i < 8; i++)  add(-32768, i == 7, -1441792);
    for (int i = 0; i < 8; i++)  add(0, 1'b0, 0);

    clear_hist();
    sample_in = 16'h1234;
    reset = 1'b1;
    #2 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check("reset_hold", filter_out, 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) drive(16'sd0, 1'b1, 32'sd0, "post_reset_zero");

    foreach (vecs[i]) drive(vecs[i].s, vecs[i].use_exp, vecs[i].e, "vector");

    for (int i = 0; i < 20; i++) drive(16'(sine[i % 20]), 1'b0, 32'sd0, "sine");

    // Asynchronous clear between edges, then restart from zero history.
    #2 reset = 1'b0;
    #1 check("async_clear", filter_out, 32'd0);
    clear_hist();
    @(posedge clk);
    #1 check("reset_held_edge", filter_out, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 20; i < 40; i++) drive(16'(sine[i % 20]), 1'b0, 32'sd0, "sine_restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
